ex_trap_csr: RTL and testbench

Parametrised execute-stage trap and CSR unit for the RV32 core. It replaces ad-hoc CSR read/write and mret/sret logic with a full unit that provides:
- csrrw/csrrs/csrrc with privilege and legality checks
- prioritised multi-source synchronous exception entry
- mret/sret privilege return, with a post-redirect flush window
- 64-bit mcycle/minstret counters
It sits beside the ALU in EX and drives the fetch redirect, the privilege mode and satp to the MMU.

---
 rtl/core_csr_pkg.sv | 55 +++++
 rtl/ex_trap_csr_if.sv | 31 +++
 rtl/csr_counter64.sv | 22 ++
 rtl/ex_trap_csr.sv | 192 +++++++++++++++++++
 tb/tb_ex_trap_csr.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_csr_pkg.sv
// rtl/core_csr_pkg.sv - shared CSR addresses, operation/privilege encodings and helpers
package core_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_SEPC      = 12'h141;
    localparam logic [11:0] CSR_SATP      = 12'h180;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [1:0] CSR_NONE = 2'b00;
    localparam logic [1:0] CSR_RW   = 2'b01;
    localparam logic [1:0] CSR_RS   = 2'b10;
    localparam logic [1:0] CSR_RC   = 2'b11;

    localparam logic [1:0] RET_NONE = 2'b00;
    localparam logic [1:0] RET_MRET = 2'b01;
    localparam logic [1:0] RET_SRET = 2'b10;
    localparam logic [1:0] RET_RSVD = 2'b11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int unsigned CAUSE_MISALIGNED_FETCH = 0;
    localparam int unsigned CAUSE_ILLEGAL          = 2;
    localparam int unsigned CAUSE_INSTR_PF         = 12;
    localparam int unsigned CAUSE_LOAD_PF          = 13;
    localparam int unsigned CAUSE_STORE_PF         = 15;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_SPP    = 8;
    localparam int unsigned MSTATUS_MPP_LO = 11;

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    function automatic logic [31:0] csr_wdata(input logic [1:0] op, input logic [31:0] old,
                                              input logic [31:0] src);
        logic [31:0] v;
        case (op)
            CSR_RS:  v = old | src;
            CSR_RC:  v = old & ~src;
            default: v = src;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ex_trap_csr_if.sv
// rtl/ex_trap_csr_if.sv - EX-stage request/response bundle for the trap and CSR unit
interface ex_trap_csr_if #(
    parameter int XLEN      = 32,
    parameter int NUM_CAUSE = 8
);
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [1:0]           csr_op;
    logic [11:0]          csr_addr;
    logic [XLEN-1:0]      csr_wsrc;
    logic [1:0]           ret_op;
    logic [NUM_CAUSE-1:0] exc_vec;
    logic [XLEN-1:0]      exc_tval;
    logic [XLEN-1:0]      csr_rdata;
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    logic                 trap_taken;
    logic [1:0]           priv_mode;
    logic [XLEN-1:0]      satp;
    logic                 flushing;

    modport master (
        output valid, pc, csr_op, csr_addr, csr_wsrc, ret_op, exc_vec, exc_tval,
        input  csr_rdata, redirect_valid, redirect_pc, trap_taken, priv_mode, satp, flushing
    );

    modport slave (
        input  valid, pc, csr_op, csr_addr, csr_wsrc, ret_op, exc_vec, exc_tval,
        output csr_rdata, redirect_valid, redirect_pc, trap_taken, priv_mode, satp, flushing
    );
endinterface

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with increment enable and per-half writes
module csr_counter64 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);
    // A write to either half wins over the increment for the whole counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            count <= '0;
        else if (wr_lo)
            count[31:0] <= wdata;
        else if (wr_hi)
            count[63:32] <= wdata;
        else if (inc)
            count <= count + 64'd1;
    end
endmodule

// File: rtl/ex_trap_csr.sv
// rtl/ex_trap_csr.sv - execute-stage CSR access, exception entry and xRET unit
module ex_trap_csr
    import core_csr_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          NUM_CAUSE    = 8,
    parameter bit          HAS_SMODE    = 1'b1,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000
) (
    input logic         clk,
    input logic         rstn,
    ex_trap_csr_if.slave bus
);
    if (XLEN != 32) begin : g_xlen_chk
        $error("ex_trap_csr supports XLEN=32 only");
    end
    if (NUM_CAUSE < 3) begin : g_cause_chk
        $error("ex_trap_csr needs NUM_CAUSE >= 3");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_flush_chk
        $error("ex_trap_csr FLUSH_CYCLES must be 1..7");
    end

    state_e      state;
    logic [2:0]  flush_cnt;
    logic [1:0]  priv, mpp;
    logic        mie, mpie, spp;
    logic [31:0] mtvec, mepc, mcause, mtval, mscratch, sepc, satp_q;
    logic [63:0] mcycle, minstret;

    logic [31:0] mstatus_val, old_val, wdata, exc_idx;
    logic        impl, csr_req, suppress, illegal, exc_any;
    logic        act, take_trap, take_ret, csr_we, retire;
    logic [NUM_CAUSE-1:0] exc_all;

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MIE]          = mie;
        mstatus_val[MSTATUS_MPIE]         = mpie;
        mstatus_val[MSTATUS_SPP]          = spp;
        mstatus_val[MSTATUS_MPP_LO +: 2]  = mpp;
    end

    always_comb begin
        old_val = '0;
        impl    = 1'b1;
        case (bus.csr_addr)
            CSR_MSTATUS:   old_val = mstatus_val;
            CSR_MTVEC:     old_val = mtvec;
            CSR_MSCRATCH:  old_val = mscratch;
            CSR_MEPC:      old_val = mepc;
            CSR_MCAUSE:    old_val = mcause;
            CSR_MTVAL:     old_val = mtval;
            CSR_SEPC:      if (HAS_SMODE) old_val = sepc;   else impl = 1'b0;
            CSR_SATP:      if (HAS_SMODE) old_val = satp_q; else impl = 1'b0;
            CSR_MCYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH: old_val = minstret[63:32];
            default:       impl = 1'b0;
        endcase
    end

    assign wdata    = csr_wdata(bus.csr_op, old_val, bus.csr_wsrc);
    assign csr_req  = bus.csr_op != CSR_NONE;
    assign suppress = (bus.csr_op == CSR_RS || bus.csr_op == CSR_RC) && bus.csr_wsrc == '0;

    assign illegal = bus.valid && (
        (csr_req && (!impl || bus.csr_addr[9:8] > priv)) ||
        (csr_req && !suppress && bus.csr_addr[11:10] == 2'b11) ||
        (bus.ret_op == RET_RSVD) ||
        (bus.ret_op == RET_MRET && priv != PRIV_M) ||
        (bus.ret_op == RET_SRET && (!HAS_SMODE || priv == PRIV_U)) ||
        (bus.ret_op != RET_NONE && csr_req));

    assign exc_all = bus.exc_vec | ({{(NUM_CAUSE-1){1'b0}}, illegal} << CAUSE_ILLEGAL);

    // Scan downward so the lowest set cause index is the one left standing.
    always_comb begin
        exc_any = 1'b0;
        exc_idx = '0;
        for (int i = NUM_CAUSE - 1; i >= 0; i--) begin
            if (exc_all[i]) begin
                exc_any = 1'b1;
                exc_idx = 32'(i);
            end
        end
    end

    assign act       = (state == ST_RUN) && bus.valid;
    assign take_trap = act && exc_any;
    assign take_ret  = act && !exc_any && bus.ret_op != RET_NONE;
    assign retire    = act && !exc_any;
    assign csr_we    = retire && bus.ret_op == RET_NONE && csr_req && !suppress;

    csr_counter64 u_mcycle (
        .clk  (clk),
        .rstn (rstn),
        .inc  (1'b1),
        .wr_lo(csr_we && bus.csr_addr == CSR_MCYCLE),
        .wr_hi(csr_we && bus.csr_addr == CSR_MCYCLEH),
        .wdata(wdata),
        .count(mcycle)
    );

    csr_counter64 u_minstret (
        .clk  (clk),
        .rstn (rstn),
        .inc  (retire),
        .wr_lo(csr_we && bus.csr_addr == CSR_MINSTRET),
        .wr_hi(csr_we && bus.csr_addr == CSR_MINSTRETH),
        .wdata(wdata),
        .count(minstret)
    );

    assign bus.csr_rdata      = old_val;
    assign bus.redirect_valid = take_trap || take_ret;
    assign bus.redirect_pc    = take_trap ? mtvec : (bus.ret_op == RET_MRET ? mepc : sepc);
    assign bus.trap_taken     = take_trap;
    assign bus.priv_mode      = priv;
    assign bus.satp           = satp_q;
    assign bus.flushing       = state == ST_FLUSH;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            priv      <= PRIV_M;
            mie       <= 1'b0;
            mpie      <= 1'b0;
            spp       <= 1'b0;
            mpp       <= PRIV_U;
            mtvec     <= MTVEC_RESET;
            mepc      <= '0;
            mcause    <= '0;
            mtval     <= '0;
            mscratch  <= '0;
            sepc      <= '0;
            satp_q    <= '0;
        end else begin
            case (state)
                ST_RUN: if (take_trap || take_ret) begin
                    state     <= ST_FLUSH;
                    flush_cnt <= 3'(FLUSH_CYCLES - 1);
                end
                ST_FLUSH: if (flush_cnt == '0) state <= ST_RUN;
                          else flush_cnt <= flush_cnt - 3'd1;
            endcase

            if (take_trap) begin
                mepc   <= bus.pc & ~32'h3;
                mcause <= exc_idx;
                mtval  <= (exc_idx == CAUSE_ILLEGAL) ? '0 : bus.exc_tval;
                mpp    <= priv;
                mpie   <= mie;
                mie    <= 1'b0;
                priv   <= PRIV_M;
            end else if (take_ret) begin
                if (bus.ret_op == RET_MRET) begin
                    priv <= mpp;
                    mie  <= mpie;
                    mpie <= 1'b1;
                    mpp  <= PRIV_U;
                end else begin
                    priv <= {1'b0, spp};
                    spp  <= 1'b0;
                end
            end else if (csr_we) begin
                case (bus.csr_addr)
                    CSR_MSTATUS: begin
                        mie  <= wdata[MSTATUS_MIE];
                        mpie <= wdata[MSTATUS_MPIE];
                        spp  <= HAS_SMODE ? wdata[MSTATUS_SPP] : 1'b0;
                        // MPP only accepts privileges this core can actually return to.
                        if (wdata[MSTATUS_MPP_LO +: 2] != 2'b10 &&
                            (HAS_SMODE || wdata[MSTATUS_MPP_LO +: 2] != PRIV_S))
                            mpp <= wdata[MSTATUS_MPP_LO +: 2];
                    end
                    CSR_MTVEC:    mtvec    <= wdata & ~32'h3;
                    CSR_MSCRATCH: mscratch <= wdata;
                    CSR_MEPC:     mepc     <= wdata & ~32'h3;
                    CSR_MCAUSE:   mcause   <= wdata;
                    CSR_MTVAL:    mtval    <= wdata;
                    CSR_SEPC:     sepc     <= wdata;
                    CSR_SATP:     satp_q   <= wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_trap_csr.sv
// tb/tb_ex_trap_csr.sv - directed self-checking bench for ex_trap_csr
module tb_ex_trap_csr;
    import core_csr_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] v;

    always #50 clk = ~clk;

    ex_trap_csr_if #(.XLEN(32), .NUM_CAUSE(16)) bus ();
    ex_trap_csr_if #(.XLEN(32), .NUM_CAUSE(8))  bus2 ();

    ex_trap_csr #(.XLEN(32), .NUM_CAUSE(16), .HAS_SMODE(1'b1), .FLUSH_CYCLES(2),
                  .MTVEC_RESET(32'h0000_0000)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    ex_trap_csr #(.XLEN(32), .NUM_CAUSE(8), .HAS_SMODE(1'b0), .FLUSH_CYCLES(2),
                  .MTVEC_RESET(32'h0000_1000)) dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.valid = 1'b0; bus.pc = '0; bus.csr_op = CSR_NONE; bus.csr_addr = '0;
        bus.csr_wsrc = '0; bus.ret_op = RET_NONE; bus.exc_vec = '0; bus.exc_tval = '0;
    endtask

    task automatic idle2();
        bus2.valid = 1'b0; bus2.pc = '0; bus2.csr_op = CSR_NONE; bus2.csr_addr = '0;
        bus2.csr_wsrc = '0; bus2.ret_op = RET_NONE; bus2.exc_vec = '0; bus2.exc_tval = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        idle();
        bus.csr_addr = a;
        #1;
        v = bus.csr_rdata;
        chk(tag, v, exp);
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w,
                         input logic [1:0] ret, input logic [15:0] exc, input logic [31:0] pcv,
                         input logic [31:0] tval);
        bus.valid = 1'b1; bus.csr_op = op; bus.csr_addr = a; bus.csr_wsrc = w;
        bus.ret_op = ret; bus.exc_vec = exc; bus.pc = pcv; bus.exc_tval = tval;
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] w);
        drive(CSR_RW, a, w, RET_NONE, 16'h0, 32'h0, 32'h0);
        cycle();
        idle();
    endtask

    initial begin
        idle();
        idle2();
        rstn = 1'b0;
        cycle();
        cycle();
        chk("rst_priv", 32'(bus.priv_mode), 32'h3);
        chk("rst_flushing", 32'(bus.flushing), 32'h0);
        chk("rst_redirect", 32'(bus.redirect_valid), 32'h0);
        chk("rst_trap", 32'(bus.trap_taken), 32'h0);
        chk("rst_satp", bus.satp, 32'h0);
        chk_csr("rst_mtvec", CSR_MTVEC, 32'h0);
        chk_csr("rst_mstatus", CSR_MSTATUS, 32'h0);
        chk_csr("rst_mcycle", CSR_MCYCLE, 32'h0);
        rstn = 1'b1;
        cycle();

        drive(CSR_RW, CSR_MTVEC, 32'h8000_0103, RET_NONE, 16'h0, 32'h0, 32'h0);
        chk("mtvec_old", bus.csr_rdata, 32'h0);
        chk("csr_no_redirect", 32'(bus.redirect_valid), 32'h0);
        cycle();
        chk_csr("mtvec_wr", CSR_MTVEC, 32'h8000_0100);
        drive(CSR_RS, CSR_MTVEC, 32'h0, RET_NONE, 16'h0, 32'h0, 32'h0);
        chk("rs0_rdata", bus.csr_rdata, 32'h8000_0100);
        chk("rs0_no_trap", 32'(bus.trap_taken), 32'h0);
        cycle();
        chk_csr("rs0_nowrite", CSR_MTVEC, 32'h8000_0100);
        chk_csr("minstret_2", CSR_MINSTRET, 32'd2);
        csr_wr(CSR_MSCRATCH, 32'h55);

        drive(CSR_NONE, 12'h0, 32'h0, RET_NONE, 16'h1004, 32'h200, 32'hDEAD);
        chk("exc_trap", 32'(bus.trap_taken), 32'h1);
        chk("exc_redirect", 32'(bus.redirect_valid), 32'h1);
        chk("exc_redirect_pc", bus.redirect_pc, 32'h8000_0100);
        cycle();
        drive(CSR_RW, CSR_MSCRATCH, 32'hBAD, RET_MRET, 16'h0001, 32'h300, 32'h0);
        chk("flush1_flushing", 32'(bus.flushing), 32'h1);
        chk("flush1_redirect", 32'(bus.redirect_valid), 32'h0);
        chk("flush1_trap", 32'(bus.trap_taken), 32'h0);
        cycle();
        chk("flush2_flushing", 32'(bus.flushing), 32'h1);
        cycle();
        idle();
        #1;
        chk("flush_done", 32'(bus.flushing), 32'h0);
        chk_csr("exc_mcause", CSR_MCAUSE, 32'd2);
        chk_csr("exc_mepc", CSR_MEPC, 32'h200);
        chk_csr("exc_mtval", CSR_MTVAL, 32'h0);
        chk_csr("flush_mscratch", CSR_MSCRATCH, 32'h55);
        chk_csr("exc_mstatus", CSR_MSTATUS, 32'h1800);
        chk_csr("exc_minstret", CSR_MINSTRET, 32'd3);
        chk("exc_priv", 32'(bus.priv_mode), 32'h3);

        csr_wr(CSR_MSTATUS, 32'h0);
        csr_wr(CSR_MEPC, 32'h400);
        drive(CSR_NONE, 12'h0, 32'h0, RET_MRET, 16'h0, 32'h0, 32'h0);
        chk("mret_redirect", 32'(bus.redirect_valid), 32'h1);
        chk("mret_pc", bus.redirect_pc, 32'h400);
        chk("mret_no_trap", 32'(bus.trap_taken), 32'h0);
        cycle();
        idle();
        #1;
        chk("mret_priv", 32'(bus.priv_mode), 32'h0);
        chk("mret_flushing", 32'(bus.flushing), 32'h1);
        cycle();
        cycle();
        chk_csr("mret_mstatus", CSR_MSTATUS, 32'h80);

        drive(CSR_RW, CSR_MSTATUS, 32'h8, RET_NONE, 16'h0, 32'h404, 32'h0);
        chk("u_csr_trap", 32'(bus.trap_taken), 32'h1);
        cycle();
        idle();
        #1;
        chk("u_trap_priv", 32'(bus.priv_mode), 32'h3);
        cycle();
        cycle();
        chk_csr("u_mcause", CSR_MCAUSE, 32'd2);
        chk_csr("u_mepc", CSR_MEPC, 32'h404);
        chk_csr("u_mstatus", CSR_MSTATUS, 32'h0);

        csr_wr(CSR_SEPC, 32'h600);
        csr_wr(CSR_MSTATUS, 32'h900);
        csr_wr(CSR_MEPC, 32'h500);
        chk_csr("s_setup_mstatus", CSR_MSTATUS, 32'h900);
        drive(CSR_NONE, 12'h0, 32'h0, RET_MRET, 16'h0, 32'h0, 32'h0);
        chk("mret_s_pc", bus.redirect_pc, 32'h500);
        cycle();
        idle();
        #1;
        chk("mret_s_priv", 32'(bus.priv_mode), 32'h1);
        cycle();
        cycle();
        chk_csr("mret_s_mstatus", CSR_MSTATUS, 32'h180);
        drive(CSR_NONE, 12'h0, 32'h0, RET_SRET, 16'h0, 32'h0, 32'h0);
        chk("sret_redirect", 32'(bus.redirect_valid), 32'h1);
        chk("sret_pc", bus.redirect_pc, 32'h600);
        chk("sret_no_trap", 32'(bus.trap_taken), 32'h0);
        cycle();
        idle();
        #1;
        chk("sret_priv", 32'(bus.priv_mode), 32'h1);
        cycle();
        cycle();
        chk_csr("sret_mstatus", CSR_MSTATUS, 32'h80);

        drive(CSR_NONE, 12'h0, 32'h0, RET_NONE, 16'hA000, 32'h700, 32'hABC);
        chk("pf_trap", 32'(bus.trap_taken), 32'h1);
        cycle();
        idle();
        cycle();
        cycle();
        chk_csr("pf_mcause", CSR_MCAUSE, 32'd13);
        chk_csr("pf_mtval", CSR_MTVAL, 32'hABC);
        chk_csr("pf_mstatus", CSR_MSTATUS, 32'h800);
        chk("pf_priv", 32'(bus.priv_mode), 32'h3);

        csr_wr(CSR_MINSTRET, 32'hFFFF_FFFF);
        chk_csr("minstret_wr_lo", CSR_MINSTRET, 32'hFFFF_FFFF);
        chk_csr("minstret_wr_hi", CSR_MINSTRETH, 32'h0);
        drive(CSR_NONE, 12'h0, 32'h0, RET_NONE, 16'h0, 32'h0, 32'h0);
        cycle();
        chk_csr("minstret_wrap_lo", CSR_MINSTRET, 32'h0);
        chk_csr("minstret_wrap_hi", CSR_MINSTRETH, 32'h1);
        csr_wr(CSR_MCYCLEH, 32'h5);
        chk_csr("mcycleh_wr", CSR_MCYCLEH, 32'h5);

        drive(CSR_RW, CSR_MSCRATCH, 32'h1234, RET_NONE, 16'h0020, 32'h800, 32'h0);
        chk("exc_csr_trap", 32'(bus.trap_taken), 32'h1);
        cycle();
        idle();
        cycle();
        cycle();
        chk_csr("exc_csr_mscratch", CSR_MSCRATCH, 32'h55);
        chk_csr("exc_csr_mcause", CSR_MCAUSE, 32'd5);

        csr_wr(CSR_SATP, 32'h8000_0001);
        chk("satp_out", bus.satp, 32'h8000_0001);
        csr_wr(CSR_MSTATUS, 32'h0);
        drive(CSR_NONE, 12'h0, 32'h0, RET_MRET, 16'h0, 32'h0, 32'h0);
        cycle();
        idle();
        #1;
        chk("pre_rst_flushing", 32'(bus.flushing), 32'h1);
        chk("pre_rst_priv", 32'(bus.priv_mode), 32'h0);
        rstn = 1'b0;
        #1;
        chk("midflush_rst_flushing", 32'(bus.flushing), 32'h0);
        chk("midflush_rst_priv", 32'(bus.priv_mode), 32'h3);
        chk("midflush_rst_satp", bus.satp, 32'h0);
        chk_csr("midflush_rst_mepc", CSR_MEPC, 32'h0);
        cycle();
        rstn = 1'b1;
        cycle();

        bus2.valid = 1'b1;
        bus2.ret_op = RET_SRET;
        #1;
        chk("nos_sret_trap", 32'(bus2.trap_taken), 32'h1);
        chk("nos_sret_pc", bus2.redirect_pc, 32'h1000);
        cycle();
        idle2();
        cycle();
        cycle();
        bus2.csr_addr = CSR_MCAUSE;
        #1;
        chk("nos_mcause", bus2.csr_rdata, 32'd2);
        bus2.valid = 1'b1;
        bus2.csr_op = CSR_RW;
        bus2.csr_addr = CSR_SEPC;
        bus2.csr_wsrc = 32'h600;
        #1;
        chk("nos_sepc_trap", 32'(bus2.trap_taken), 32'h1);
        chk("nos_sepc_rdata", bus2.csr_rdata, 32'h0);
        cycle();
        idle2();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
